// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Bundles the write, read and status signals of the UART
//                receive FIFO.
//                slave  modport : the FIFO itself
//                master modport : receiver/consumer side driving the FIFO
//  Signals     : din[DATA_W]  receiver byte, sampled when rx_done=1
//                rx_done      one-cycle write strobe from the receiver
//                rd_en        consumer pop request
//                clr_ovf      one-cycle clear of the sticky overflow flag
//                dout[DATA_W] byte delivered to the consumer
//                dout_valid   dout carries a valid byte
//                empty / full occupancy flags
//                count[AW+1]  bytes stored, 0..DEPTH
//                overflow     sticky: a byte was dropped while full
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
);
  localparam int c_AW = $clog2(DEPTH);

  logic [DATA_W-1:0] din;
  logic              rx_done;
  logic              rd_en;
  logic              clr_ovf;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              empty;
  logic              full;
  logic [c_AW:0]     count;
  logic              overflow;

  modport slave (
    input  din,
    input  rx_done,
    input  rd_en,
    input  clr_ovf,
    output dout,
    output dout_valid,
    output empty,
    output full,
    output count,
    output overflow
  );

  modport master (
    output din,
    output rx_done,
    output rd_en,
    output clr_ovf,
    input  dout,
    input  dout_valid,
    input  empty,
    input  full,
    input  count,
    input  overflow
  );
endinterface : uart_rx_fifo_if
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Receive-side byte buffer sitting directly behind the UART
//                receiver. Captures each byte strobed by rx_done, stores up
//                to DEPTH bytes and hands them to the consumer via rd_en.
//                A byte arriving while full is dropped and flags the sticky
//                overflow bit.
//  Ports       : clk        system clock
//                rstN       asynchronous active-low reset
//                bus        uart_rx_fifo_if.slave (din, rx_done, rd_en,
//                           clr_ovf in; dout, dout_valid, empty, full,
//                           count, overflow out)
//  Options     : UART_RX_FIFO_FWFT_EN - first-word-fall-through read port
//                (dout shows the head byte combinationally, dout_valid is
//                !empty). Undefined: registered read, dout_valid is a
//                one-cycle response pulse after each accepted read.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8
) (
  input  wire             clk,
  input  wire             rstN,
  uart_rx_fifo_if.slave   bus
);

  localparam int            c_AW         = $clog2(DEPTH);
  localparam logic [c_AW:0] c_COUNT_FULL = DEPTH[c_AW:0];
  localparam logic [c_AW:0] c_COUNT_ONE  = {{c_AW{1'b0}}, 1'b1};
  localparam logic [c_AW-1:0] c_PTR_ONE  = {{(c_AW-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_overflow;

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_wr_rej;
  logic [c_AW:0]     w_count_nxt;

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  // A read is only honoured when something is stored; rd_en on an empty FIFO
  // is silently ignored. A read in the same cycle frees the slot the write
  // needs, so a full FIFO still accepts a byte when it is also being popped.
  assign w_rd_acc = bus.rd_en & ~r_empty;
  assign w_wr_acc = bus.rx_done & (~r_full | w_rd_acc);
  assign w_wr_rej = bus.rx_done & r_full & ~w_rd_acc;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + c_COUNT_ONE;
      2'b01:   w_count_nxt = r_count - c_COUNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // --------------------------------------------------------------------------
  // Byte array: contents deliberately not reset
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= bus.din;
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy and flags
  // --------------------------------------------------------------------------
  // Pointers are exactly AW bits wide, so DEPTH-1 -> 0 wraps for free.
  // empty/full are registered from the next count so they line up with it.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == c_COUNT_FULL);
    end
  end

  // Sticky overflow: a dropped byte beats a coincident clear so the event is
  // never lost.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_overflow <= 1'b0;
    end else if (w_wr_rej) begin
      r_overflow <= 1'b1;
    end else if (bus.clr_ovf) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.count    = r_count;
  assign bus.empty    = r_empty;
  assign bus.full     = r_full;
  assign bus.overflow = r_overflow;

  // --------------------------------------------------------------------------
  // Read port
  // --------------------------------------------------------------------------
`ifdef UART_RX_FIFO_FWFT_EN
  // Head byte falls through: the consumer samples dout in the cycle it
  // raises rd_en. When empty, dout is meaningless and dout_valid is low.
  assign bus.dout       = r_mem[r_rd_ptr];
  assign bus.dout_valid = ~r_empty;
`else
  logic [DATA_W-1:0] r_dout;
  logic              r_dout_valid;

  // Registered read: the head byte is captured at the accepting edge and
  // held; dout_valid pulses for the one cycle following that edge. When full
  // with a coincident write, wr_ptr == rd_ptr, but the non-blocking capture
  // still sees the old head byte.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
    end else begin
      r_dout_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_dout <= r_mem[r_rd_ptr];
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_dout_valid;
`endif

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Self-checking bench for uart_rx_fifo. Directed stimulus;
//                each accepted read pushes its expected byte into a queue
//                and an independent monitor pops and compares whenever the
//                FIFO presents a byte. Status outputs are compared against
//                a reference occupancy queue and hand-computed constants.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  localparam int c_DEPTH  = 16;
  localparam int c_DATA_W = 8;

  logic clk;
  logic rstN;

  uart_rx_fifo_if #(.DEPTH(c_DEPTH), .DATA_W(c_DATA_W)) bus ();

  uart_rx_fifo #(.DEPTH(c_DEPTH), .DATA_W(c_DATA_W)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q[$];   // bytes the consumer must see, in order
  logic [7:0] model_q[$]; // reference contents of the FIFO
  logic       model_ovf;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    logic present;
`ifdef UART_RX_FIFO_FWFT_EN
    present = rstN && bus.rd_en && bus.dout_valid;
`else
    present = rstN && bus.dout_valid;
`endif
    if (present) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", bus.dout, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("dout_byte", {24'd0, bus.dout}, {24'd0, e});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers. Called at posedge+1; return at next posedge+1.
  // --------------------------------------------------------------------------
  task automatic op(input logic rx, input logic [7:0] d, input logic rd,
                    input logic clr);
    logic rd_acc, wr_acc, wr_rej;
    rd_acc = rd && (model_q.size() > 0);
    wr_acc = rx && ((model_q.size() < c_DEPTH) || rd_acc);
    wr_rej = rx && !wr_acc;
    if (rd_acc) exp_q.push_back(model_q.pop_front());
    if (wr_acc) model_q.push_back(d);
    if (wr_rej) model_ovf = 1'b1;
    else if (clr) model_ovf = 1'b0;

    bus.rx_done = rx;
    bus.din     = d;
    bus.rd_en   = rd;
    bus.clr_ovf = clr;
    @(posedge clk);
    #1;
    bus.rx_done = 1'b0;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    check("count",    {27'd0, bus.count}, model_q.size());
    check("empty",    {31'd0, bus.empty}, {31'd0, model_q.size() == 0});
    check("full",     {31'd0, bus.full},  {31'd0, model_q.size() == c_DEPTH});
    check("overflow", {31'd0, bus.overflow}, {31'd0, model_ovf});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) op(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    bus.din = 8'h00; bus.rx_done = 1'b0; bus.rd_en = 1'b0; bus.clr_ovf = 1'b0;
    model_ovf = 1'b0;
    rstN = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count",    {27'd0, bus.count}, 32'd0);
    check("rst_empty",    {31'd0, bus.empty}, 32'd1);
    check("rst_full",     {31'd0, bus.full}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
`ifndef UART_RX_FIFO_FWFT_EN
    check("rst_dout",       {24'd0, bus.dout}, 32'd0);
    check("rst_dout_valid", {31'd0, bus.dout_valid}, 32'd0);
`endif
    rstN = 1'b1;
    @(posedge clk); #1;

    // Three bytes in, three out in order
    op(1'b1, 8'hA5, 1'b0, 1'b0);
    op(1'b1, 8'h3C, 1'b0, 1'b0);
    op(1'b1, 8'h7E, 1'b0, 1'b0);
    check("three_count", {27'd0, bus.count}, 32'd3);
    check("three_empty", {31'd0, bus.empty}, 32'd0);
`ifdef UART_RX_FIFO_FWFT_EN
    check("fwft_head",  {24'd0, bus.dout}, 32'hA5);
    check("fwft_valid", {31'd0, bus.dout_valid}, 32'd1);
`else
    check("no_read_valid", {31'd0, bus.dout_valid}, 32'd0);
`endif
    for (int i = 0; i < 3; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_count", {27'd0, bus.count}, 32'd0);
    check("drain_empty", {31'd0, bus.empty}, 32'd1);
    idle(2);

    // Fill to full, then drop one byte
    for (int i = 0; i < 16; i++) op(1'b1, 8'(i), 1'b0, 1'b0);
    check("fill_full",  {31'd0, bus.full}, 32'd1);
    check("fill_count", {27'd0, bus.count}, 32'd16);
    op(1'b1, 8'hFF, 1'b0, 1'b0);
    check("drop_overflow", {31'd0, bus.overflow}, 32'd1);
    check("drop_count",    {27'd0, bus.count}, 32'd16);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_alone", {31'd0, bus.overflow}, 32'd0);

    // Full with coincident write and read: accepted, count stays 16
    op(1'b1, 8'h55, 1'b1, 1'b0);
    check("full_rw_count", {27'd0, bus.count}, 32'd16);
    check("full_rw_ovf",   {31'd0, bus.overflow}, 32'd0);
    for (int i = 0; i < 16; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    check("full_drain_empty", {31'd0, bus.empty}, 32'd1);
    idle(2);

    // Pointer wrap: 40 write/read pairs
    for (int i = 0; i < 40; i++) begin
      op(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      check("wrap_count_1", {27'd0, bus.count}, 32'd1);
      op(1'b0, 8'h00, 1'b1, 1'b0);
    end
    idle(2);

    // Read on empty is ignored; empty with rx_done+rd_en stores one byte
    op(1'b0, 8'h00, 1'b1, 1'b0);
    check("empty_rd_count", {27'd0, bus.count}, 32'd0);
`ifndef UART_RX_FIFO_FWFT_EN
    check("empty_rd_valid", {31'd0, bus.dout_valid}, 32'd0);
`endif
    op(1'b1, 8'h42, 1'b1, 1'b0);
    check("empty_rw_count", {27'd0, bus.count}, 32'd1);
    op(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Overflow: set wins over coincident clear
    for (int i = 0; i < 16; i++) op(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    op(1'b1, 8'hEE, 1'b0, 1'b0);
    op(1'b1, 8'hEF, 1'b0, 1'b1);
    check("set_beats_clr", {31'd0, bus.overflow}, 32'd1);
    op(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_after", {31'd0, bus.overflow}, 32'd0);
    op(1'b1, 8'hEE, 1'b0, 1'b0);

    // Drain to five bytes, then asynchronous reset
    for (int i = 0; i < 11; i++) op(1'b0, 8'h00, 1'b1, 1'b0);
    idle(2);
    check("pre_rst_count", {27'd0, bus.count}, 32'd5);
    check("pre_rst_ovf",   {31'd0, bus.overflow}, 32'd1);
    #2 rstN = 1'b0;
    #1;
    check("async_count", {27'd0, bus.count}, 32'd0);
    check("async_empty", {31'd0, bus.empty}, 32'd1);
    check("async_ovf",   {31'd0, bus.overflow}, 32'd0);
    check("async_full",  {31'd0, bus.full}, 32'd0);
    model_q.delete();
    model_ovf = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    @(posedge clk); #1;
    op(1'b1, 8'h99, 1'b0, 1'b0);
`ifdef UART_RX_FIFO_FWFT_EN
    check("post_rst_head", {24'd0, bus.dout}, 32'h99);
`endif
    op(1'b0, 8'h00, 1'b1, 1'b0);

    // Bounded wait for the scoreboard to drain
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx_fifo
`default_nettype wire
